// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: FSM states, CRC-32 constants and
// the preamble/SFD nibble values seen on the MII.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Reflected IEEE 802.3 CRC-32 polynomial and its starting value
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Register value left behind after running the CRC over data plus a correct FCS
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [3:0]  NIB_PREAMBLE = 4'h5;
    localparam logic [3:0]  NIB_SFD      = 4'hD;

    // The last four bytes are FCS, so five must be held before the oldest is payload
    localparam int          DLY_DEPTH    = 5;

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB of the byte first).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Fold the byte in, then shift out its eight bits one at a time
    always_comb begin
        c = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx.sv
// MII receiver: strips preamble/SFD, assembles bytes from nibbles, checks
// the FCS and streams the payload (FCS removed) as single-cycle beats.
module mii_rx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter bit CHECK_FCS       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rxd,
    input  logic       rx_dv,
    input  logic       rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_frame_good,
    output logic       stat_bad_fcs,
    output logic       stat_bad_frame
);

    localparam logic [2:0]  FULL    = 3'(DLY_DEPTH);
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;      // 1 while waiting for the high nibble
    logic [3:0]  low_q, low_d;
    logic [7:0]  dly_q [DLY_DEPTH];
    logic [7:0]  dly_d [DLY_DEPTH];
    logic [2:0]  held_q, held_d;
    logic [10:0] count_q, count_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic        err_q, err_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        good_q, good_d;
    logic        bad_fcs_q, bad_fcs_d;
    logic        bad_frame_q, bad_frame_d;

    logic [7:0]  byte_in;
    logic        fcs_fail;
    logic        other_err;

    assign byte_in = {rxd, low_q};

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (byte_in),
        .crc_out (crc_next)
    );

    // Error sources judged at frame end: FCS separately so it can get its own status
    always_comb begin
        fcs_fail  = CHECK_FCS && (crc_q != CRC_RESIDUE);
        other_err = err_q || phase_q || (count_q < MIN_LEN);
    end

    // Receive FSM, byte assembly, delay line and end-of-frame decisions
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        low_d       = low_q;
        dly_d       = dly_q;
        held_d      = held_q;
        count_d     = count_q;
        crc_d       = crc_q;
        err_d       = err_q;
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        good_d      = 1'b0;
        bad_fcs_d   = 1'b0;
        bad_frame_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    if (rxd == NIB_PREAMBLE) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        state_d     = ST_DROP;
                        bad_frame_d = 1'b1;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!rx_dv || rx_er) begin
                    state_d     = ST_DROP;
                    bad_frame_d = 1'b1;
                end else if (rxd == NIB_SFD) begin
                    state_d = ST_DATA;
                    phase_d = 1'b0;
                end else if (rxd != NIB_PREAMBLE) begin
                    state_d     = ST_DROP;
                    bad_frame_d = 1'b1;
                end
            end

            ST_DATA: begin
                if (rx_dv) begin
                    if (rx_er) begin
                        err_d = 1'b1;
                    end
                    if (!phase_q) begin
                        low_d   = rxd;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        crc_d   = crc_next;
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + 11'd1;
                        end
                        if (held_q == FULL) begin
                            tvalid_d = 1'b1;
                            tdata_d  = dly_q[0];
                            for (int i = 0; i < DLY_DEPTH - 1; i++) begin
                                dly_d[i] = dly_q[i+1];
                            end
                            dly_d[DLY_DEPTH-1] = byte_in;
                        end else begin
                            for (int i = 0; i < DLY_DEPTH; i++) begin
                                if (held_q == 3'(i)) begin
                                    dly_d[i] = byte_in;
                                end
                            end
                            held_d = held_q + 3'd1;
                        end
                    end
                end else begin
                    if (held_q == FULL) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tdata_d  = dly_q[0];
                        tuser_d  = other_err || fcs_fail;
                        if (other_err) begin
                            bad_frame_d = 1'b1;
                        end else if (fcs_fail) begin
                            bad_fcs_d = 1'b1;
                        end else begin
                            good_d = 1'b1;
                        end
                    end else begin
                        bad_frame_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                    held_d  = 3'd0;
                    count_d = 11'd0;
                    crc_d   = CRC_INIT;
                    err_d   = 1'b0;
                    for (int i = 0; i < DLY_DEPTH; i++) begin
                        dly_d[i] = 8'd0;
                    end
                end
            end

            default: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers; reset parks in DROP so a frame already in flight is skipped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DROP;
            phase_q     <= 1'b0;
            low_q       <= 4'd0;
            for (int i = 0; i < DLY_DEPTH; i++) begin
                dly_q[i] <= 8'd0;
            end
            held_q      <= 3'd0;
            count_q     <= 11'd0;
            crc_q       <= CRC_INIT;
            err_q       <= 1'b0;
            tdata_q     <= 8'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            good_q      <= 1'b0;
            bad_fcs_q   <= 1'b0;
            bad_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            low_q       <= low_d;
            dly_q       <= dly_d;
            held_q      <= held_d;
            count_q     <= count_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            good_q      <= good_d;
            bad_fcs_q   <= bad_fcs_d;
            bad_frame_q <= bad_frame_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tuser    = tuser_q;
    assign stat_frame_good = good_q;
    assign stat_bad_fcs    = bad_fcs_q;
    assign stat_bad_frame  = bad_frame_q;

endmodule

// File: tb/tb_mii_rx.sv
// Bench for mii_rx: drives MII frames (directed and random) and compares the
// received beats and status pulses with a frame-level reference model.
module tb_mii_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rxd;
    logic       rx_dv;
    logic       rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_frame_good;
    logic       stat_bad_fcs;
    logic       stat_bad_frame;

    int check_count = 0;
    int error_count = 0;

    logic [7:0] frame_q [$];
    logic [7:0] beat_q [$];
    logic       last_q [$];
    logic       user_seen;
    int         good_cnt;
    int         fcs_cnt;
    int         bad_cnt;

    always #20 clk = ~clk;

    mii_rx dut (
        .clk             (clk),
        .reset           (reset),
        .rxd             (rxd),
        .rx_dv           (rx_dv),
        .rx_er           (rx_er),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .stat_frame_good (stat_frame_good),
        .stat_bad_fcs    (stat_bad_fcs),
        .stat_bad_frame  (stat_bad_frame)
    );

    // Collect beats and status pulses away from the active edge
    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            beat_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
            if (m_axis_tlast) begin
                user_seen = m_axis_tuser;
            end
        end
        if (stat_frame_good) good_cnt = good_cnt + 1;
        if (stat_bad_fcs)    fcs_cnt  = fcs_cnt + 1;
        if (stat_bad_frame)  bad_cnt  = bad_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        beat_q.delete();
        last_q.delete();
        user_seen = 1'b0;
        good_cnt  = 0;
        fcs_cnt   = 0;
        bad_cnt   = 0;
    endtask

    task automatic sendNibble(input logic [3:0] n, input logic dv, input logic er);
        rxd   = n;
        rx_dv = dv;
        rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic sendIdle(input int cycles);
        repeat (cycles) sendNibble(4'h0, 1'b0, 1'b0);
    endtask

    task automatic sendPreamble();
        repeat (15) sendNibble(4'h5, 1'b1, 1'b0);
        sendNibble(4'hD, 1'b1, 1'b0);
    endtask

    task automatic sendByte(input int idx, input logic er);
        logic [7:0] b;
        b = frame_q[idx];
        sendNibble(b[3:0], 1'b1, er);
        sendNibble(b[7:4], 1'b1, 1'b0);
    endtask

    // Ethernet FCS of the first len bytes of frame_q (final complement applied)
    function automatic logic [31:0] fcsOf(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, frame_q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Payload (incrementing or random) followed by its FCS, optionally corrupted
    task automatic buildFrame(input int len, input bit incr, input int flip_bit);
        logic [31:0] fcs;
        frame_q.delete();
        for (int i = 0; i < len; i++) begin
            frame_q.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
        end
        fcs = fcsOf(len);
        if (flip_bit >= 0) begin
            fcs[flip_bit] = ~fcs[flip_bit];
        end
        for (int k = 0; k < 4; k++) begin
            frame_q.push_back(fcs[8*k +: 8]);
        end
    endtask

    task automatic checkNothing(input string name);
        checkOutput({name, " beats"}, beat_q.size(), 0);
        checkOutput({name, " good"}, good_cnt, 0);
        checkOutput({name, " badfcs"}, fcs_cnt, 0);
    endtask

    // Frame-level reference: last 4 bytes are FCS, the rest is payload
    task automatic checkFrame(input string name, input bit had_er, input bit odd);
        int          total;
        int          exp_beats;
        int          first_last;
        int          n_last;
        bit          fcs_ok;
        bit          other;
        logic [31:0] fcs_rx;
        total = frame_q.size();
        fcs_ok = 1'b0;
        if (total >= 4) begin
            fcs_rx = {frame_q[total-1], frame_q[total-2], frame_q[total-3], frame_q[total-4]};
            fcs_ok = (fcs_rx == fcsOf(total - 4));
        end
        other = had_er || odd || (total < 64);
        exp_beats = (total >= 5) ? total - 4 : 0;

        checkOutput({name, " beats"}, beat_q.size(), exp_beats);
        for (int i = 0; i < beat_q.size() && i < exp_beats; i++) begin
            checkOutput({name, " data"}, beat_q[i], frame_q[i]);
        end
        n_last = 0;
        first_last = -1;
        for (int i = 0; i < last_q.size(); i++) begin
            if (last_q[i]) begin
                n_last++;
                if (first_last < 0) first_last = i;
            end
        end
        checkOutput({name, " tlast cnt"}, n_last, (exp_beats > 0) ? 1 : 0);
        if (exp_beats > 0) begin
            checkOutput({name, " tlast pos"}, first_last, exp_beats - 1);
            checkOutput({name, " tuser"}, user_seen, other || !fcs_ok);
            checkOutput({name, " good"}, good_cnt, (!other && fcs_ok) ? 1 : 0);
            checkOutput({name, " badfcs"}, fcs_cnt, (!other && !fcs_ok) ? 1 : 0);
            checkOutput({name, " badframe"}, bad_cnt, other ? 1 : 0);
        end else begin
            checkOutput({name, " good"}, good_cnt, 0);
            checkOutput({name, " badfcs"}, fcs_cnt, 0);
            checkOutput({name, " badframe"}, bad_cnt, 1);
        end
    endtask

    // Send frame_q with preamble/SFD; optional rx_er on one byte and a stray trailing nibble
    task automatic applyStimulus(input string name, input int er_byte, input bit odd);
        clearMonitor();
        sendPreamble();
        for (int i = 0; i < frame_q.size(); i++) begin
            sendByte(i, i == er_byte);
        end
        if (odd) begin
            sendNibble(4'($urandom_range(0, 15)), 1'b1, 1'b0);
        end
        sendIdle(6);
        checkFrame(name, er_byte >= 0, odd);
    endtask

    initial begin
        int len;
        int flip;
        int er;
        bit odd;

        reset = 1'b1;
        rxd   = 4'h0;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        clearMonitor();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset outs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                                   stat_frame_good, stat_bad_fcs, stat_bad_frame}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sendIdle(2);

        buildFrame(60, 1'b1, -1);
        applyStimulus("good60", -1, 1'b0);

        buildFrame(60, 1'b1, 0);
        applyStimulus("fcsflip", -1, 1'b0);

        buildFrame(60, 1'b1, -1);
        applyStimulus("rxer10", 10, 1'b0);

        // Broken preamble, then junk that must be ignored until rx_dv drops
        clearMonitor();
        sendNibble(4'h5, 1'b1, 1'b0);
        sendNibble(4'h5, 1'b1, 1'b0);
        sendNibble(4'h3, 1'b1, 1'b0);
        repeat (8) sendNibble(4'($urandom_range(0, 15)), 1'b1, 1'b0);
        sendIdle(6);
        checkNothing("badpre");
        checkOutput("badpre badframe", bad_cnt, 1);
        buildFrame(60, 1'b1, -1);
        applyStimulus("afterpre", -1, 1'b0);

        // Three raw bytes after the SFD: too short to produce any beat
        frame_q.delete();
        for (int i = 0; i < 3; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        applyStimulus("short3", -1, 1'b0);

        buildFrame(16, 1'b0, -1);
        applyStimulus("runt20", -1, 1'b0);

        // Reset mid-payload while a beat is on the outputs
        buildFrame(60, 1'b1, -1);
        clearMonitor();
        sendPreamble();
        for (int i = 0; i < 10; i++) sendByte(i, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midrst outs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                                    stat_frame_good, stat_bad_fcs, stat_bad_frame}, 0);
        clearMonitor();
        sendByte(10, 1'b0);
        sendByte(11, 1'b0);
        reset = 1'b0;
        for (int i = 12; i < frame_q.size(); i++) sendByte(i, 1'b0);
        sendIdle(6);
        checkNothing("midrst");
        checkOutput("midrst badframe", bad_cnt, 0);
        buildFrame(60, 1'b1, -1);
        applyStimulus("afterrst", -1, 1'b0);

        // Random frames with random corruption
        for (int n = 0; n < 25; n++) begin
            len  = $urandom_range(0, 80);
            flip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1;
            buildFrame(len, 1'b0, flip);
            er   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len + 3)) : -1;
            odd  = ($urandom_range(0, 5) == 0);
            applyStimulus("rand", er, odd);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
